// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if
//   Groups the issue-side and result-side handshake signals of the execute
//   stage so that they travel together through the hierarchy.
//
//   Issue side (master drives, slave samples):
//     in_valid, alu_ctrl[3:0], op_a[WIDTH-1:0], op_b[WIDTH-1:0], shamt[4:0],
//     acc_clr, out_ready
//   Result side (slave drives, master samples):
//     in_ready, out_valid, result[WIDTH-1:0], zero, overflow, busy
//
//   The master modport is for whoever issues operations and consumes
//   results. The slave modport is for alu_exec_stage.
interface alu_exec_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       shamt;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, shamt, acc_clr, out_ready,
    input  in_ready, out_valid, result, zero, overflow, busy
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, shamt, acc_clr, out_ready,
    output in_ready, out_valid, result, zero, overflow, busy
  );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   This is the execute-stage datapath. It accepts one operation per
//   valid/ready handshake. Logic, add/sub, compare and shift operations
//   return a registered result one cycle after they are accepted. MULA
//   multiplies op_a by op_b with a shift-add multiplier that takes WIDTH
//   cycles. It then adds the low WIDTH bits of the product into an internal
//   accumulator, and returns the new accumulator value as the result.
//
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - alu_exec_stage_if.slave, which carries:
//       in_valid / in_ready   : operation handshake
//       alu_ctrl, op_a, op_b, shamt : operation code and operands
//       acc_clr               : synchronous accumulator clear (honoured in IDLE)
//       out_valid / out_ready : result handshake
//       result, zero, overflow: registered result and its flags
//       busy                  : high while MULA iterates
//
//   Parameters:
//     WIDTH     - operand/result width; MULA takes WIDTH busy cycles
//     ACC_RESET - reset and clear value of the accumulator
//
//   Build option:
//     ALU_OVERFLOW_EN - when defined, overflow flags signed overflow of
//                       ADD/SUB. When undefined, overflow is tied to 0.
module alu_exec_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input logic            clk,
  input logic            rst_n,
  alu_exec_stage_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_MULA = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_ADDU = 4'b1000;
  localparam logic [3:0] OP_SUBU = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0] acc_sum;
  logic             mul_done;

  // Holding rst_n in the ready term keeps in_ready low throughout reset.
  assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign sum_ab  = bus.op_a + bus.op_b;
  assign diff_ab = bus.op_a - bus.op_b;

  // One shift-add step. Only the low WIDTH product bits are needed, so the
  // multiplicand shifts left within WIDTH bits and the multiplier shifts
  // right. After WIDTH steps, prod holds the wrapped product.
  assign mul_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign acc_sum  = acc_q + mul_sum;
  assign mul_done = (state_q == ST_MUL) && (cnt_q == CNT_LAST);

  always_comb begin
    alu_res = '0;
    unique case (bus.alu_ctrl)
      OP_AND:  alu_res = bus.op_a & bus.op_b;
      OP_OR:   alu_res = bus.op_a | bus.op_b;
      OP_XOR:  alu_res = bus.op_a ^ bus.op_b;
      OP_NOR:  alu_res = ~(bus.op_a | bus.op_b);
      OP_ADD,
      OP_ADDU: alu_res = sum_ab;
      OP_SUB,
      OP_SUBU: alu_res = diff_ab;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
      OP_SLL:  alu_res = bus.op_b << bus.shamt;
      OP_SRL:  alu_res = bus.op_b >> bus.shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.op_b) >>> bus.shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == ST_IDLE) begin
      // The clear comes first. A MULA accepted on the same edge therefore
      // starts from ACC_RESET, because the accumulator does not change until
      // that MULA completes.
      if (bus.acc_clr) begin
        acc_d = ACC_RESET;
      end
      if (accept) begin
        if (bus.alu_ctrl == OP_MULA) begin
          state_d  = ST_MUL;
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          prod_d   = '0;
          cnt_d    = '0;
        end else begin
          result_d    = alu_res;
          zero_d      = (alu_res == '0);
          out_valid_d = 1'b1;
        end
      end
    end else begin
      prod_d   = mul_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_ONE;
      if (mul_done) begin
        acc_d       = acc_sum;
        result_d    = acc_sum;
        zero_d      = (acc_sum == '0);
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      acc_q       <= ACC_RESET;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic alu_ovf;

  // Signed overflow occurs when the effective operand signs agree and the
  // result sign differs. For SUB, the sign of op_b is inverted.
  always_comb begin
    alu_ovf = 1'b0;
    if (bus.alu_ctrl == OP_ADD) begin
      alu_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                (sum_ab[WIDTH-1] != bus.op_a[WIDTH-1]);
    end else if (bus.alu_ctrl == OP_SUB) begin
      alu_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                (diff_ab[WIDTH-1] != bus.op_a[WIDTH-1]);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == ST_IDLE) && accept && (bus.alu_ctrl != OP_MULA)) begin
      ovf_d = alu_ovf;
    end else if (mul_done) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage
//   Self-checking bench for alu_exec_stage. It runs a table of directed
//   vectors, hand-written MULA, reset and backpressure sequences, and a
//   randomized run. Expected values come from constants and from a
//   behavioural model of the operation set and the accumulator.
module tb_alu_exec_stage;

  localparam int WIDTH = 32;

`ifdef ALU_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_acc = 32'h0;

  alu_exec_stage_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_stage #(.WIDTH(WIDTH), .ACC_RESET('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Safety net in case a bounded wait is ever bypassed.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    bit          zero;
    bit          ovf;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Presents one operation, waits (bounded) for in_ready and returns just
  // after the accepting edge.
  task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh,
                               input logic clr);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.alu_ctrl = c;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.shamt    = sh;
    bus.acc_clr  = clr;
    #1;
    while (!bus.in_ready && w < 100) begin
      tick();
      w++;
    end
    checkOutput("in_ready_before_accept", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
  endtask

  // Issues an operation, measures latency and busy cycles, checks the
  // result, and then lets it be consumed.
  task automatic runOp(input string name, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic clr,
                       input logic [31:0] exp_res, input bit exp_zero,
                       input bit exp_ovf, input int exp_lat, input int exp_busy);
    int cyc;
    int busy_cnt;
    applyStimulus(c, a, b, sh, clr);
    cyc      = 1;
    busy_cnt = 0;
    while (!bus.out_valid && cyc < 200) begin
      if (bus.busy) busy_cnt++;
      tick();
      cyc++;
    end
    checkOutput({name, "_latency"}, cyc, exp_lat);
    checkOutput({name, "_result"}, bus.result, exp_res);
    checkOutput({name, "_zero"}, {31'b0, bus.zero}, {31'b0, exp_zero});
    checkOutput({name, "_overflow"}, {31'b0, bus.overflow}, {31'b0, exp_ovf});
    checkOutput({name, "_busy_cycles"}, busy_cnt, exp_busy);
    tick();
  endtask

  // Reference behaviour of the operation set, written with wide signed
  // arithmetic instead of bit-level tricks.
  function automatic void refModel(input logic [3:0] c, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh,
                                   output logic [31:0] r, output bit v);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    v  = 1'b0;
    r  = 32'h0;
    case (c)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd10: r = a ^ b;
      4'd12: r = ~(a | b);
      4'd2: begin
        s = sa + sb;
        r = s[31:0];
        v = OVF_EN && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      4'd8:  r = a + b;
      4'd6: begin
        s = sa - sb;
        r = s[31:0];
        v = OVF_EN && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      4'd9:  r = a - b;
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd11: r = (a < b) ? 32'd1 : 32'd0;
      4'd3:  r = b << sh;
      4'd4:  r = b >> sh;
      4'd13: begin
        s = sb >>> sh;
        r = s[31:0];
      end
      default: r = 32'h0;
    endcase
  endfunction

  task automatic runModelOp(input string name, input logic [3:0] c,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh, input logic clr);
    logic [31:0] r;
    bit          v;
    if (clr) ref_acc = 32'h0;
    if (c == 4'd5) begin
      ref_acc = ref_acc + a * b;
      runOp(name, c, a, b, sh, clr, ref_acc, ref_acc == 32'h0, 1'b0, WIDTH + 1, WIDTH);
    end else begin
      refModel(c, a, b, sh, r, v);
      runOp(name, c, a, b, sh, clr, r, r == 32'h0, v, 1, 0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"add",       4'b0010, 32'd5,        32'd7,        5'd0,  32'd12,       1'b0, 1'b0});
    vecs.push_back('{"sub_zero",  4'b0110, 32'd9,        32'd9,        5'd0,  32'd0,        1'b1, 1'b0});
    vecs.push_back('{"sra",       4'b1101, 32'h1234,     32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0});
    vecs.push_back('{"sltu",      4'b1011, 32'd1,        32'hFFFFFFFF, 5'd0,  32'd1,        1'b0, 1'b0});
    vecs.push_back('{"slt_eq",    4'b0111, 32'hFFFFFFFB, 32'hFFFFFFFB, 5'd0,  32'd0,        1'b1, 1'b0});
    vecs.push_back('{"slt_neg",   4'b0111, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        1'b0, 1'b0});
    vecs.push_back('{"add_ovf",   4'b0010, 32'h7FFFFFFF, 32'd1,        5'd0,  32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{"addu",      4'b1000, 32'h7FFFFFFF, 32'd1,        5'd0,  32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{"sub_ovf",   4'b0110, 32'h80000000, 32'd1,        5'd0,  32'h7FFFFFFF, 1'b0, 1'b1});
    vecs.push_back('{"subu",      4'b1001, 32'd0,        32'd1,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{"and",       4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0});
    vecs.push_back('{"or",        4'b0001, 32'h0F0F0000, 32'h000000FF, 5'd0,  32'h0F0F00FF, 1'b0, 1'b0});
    vecs.push_back('{"xor",       4'b1010, 32'hFFFF0000, 32'h0FF00FF0, 5'd0,  32'hF00F0FF0, 1'b0, 1'b0});
    vecs.push_back('{"nor",       4'b1100, 32'd0,        32'd0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{"sll",       4'b0011, 32'h5,        32'd1,        5'd31, 32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{"srl",       4'b0100, 32'h5,        32'h80000000, 5'd31, 32'd1,        1'b0, 1'b0});
    vecs.push_back('{"code1110",  4'b1110, 32'hFFFFFFFF, 32'h12345678, 5'd3,  32'd0,        1'b1, 1'b0});
    vecs.push_back('{"code1111",  4'b1111, 32'hFFFFFFFF, 32'h12345678, 5'd3,  32'd0,        1'b1, 1'b0});

    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = 4'd0;
    bus.op_a      = 32'h0;
    bus.op_b      = 32'h0;
    bus.shamt     = 5'd0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #1;
    checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'd0);
    tick();
    tick();
    checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("reset_result", bus.result, 32'd0);
    checkOutput("reset_zero", {31'b0, bus.zero}, 32'd0);
    checkOutput("reset_overflow", {31'b0, bus.overflow}, 32'd0);
    checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Directed single-cycle vectors
    $display("[TB] directed vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      runOp(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh, 1'b0,
            vecs[i].res, vecs[i].zero, OVF_EN && vecs[i].ovf, 1, 0);
    end

    // MULA accumulation with a clear on the first accept
    $display("[TB] mula accumulation");
    runOp("mula_3x4", 4'b0101, 32'd3, 32'd4, 5'd0, 1'b1, 32'd12, 1'b0, 1'b0, 33, 32);
    runOp("mula_5x6", 4'b0101, 32'd5, 32'd6, 5'd0, 1'b0, 32'd42, 1'b0, 1'b0, 33, 32);
    runOp("mula_wrap", 4'b0101, 32'hFFFFFFFF, 32'd2, 5'd0, 1'b0, 32'd40, 1'b0, 1'b0, 33, 32);
    ref_acc = 32'd40;

    // acc_clr issued mid-MUL must be ignored: 40 + 1*1 = 41
    applyStimulus(4'b0101, 32'd1, 32'd1, 5'd0, 1'b0);
    repeat (5) tick();
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    repeat (40) begin
      if (!bus.out_valid) tick();
    end
    checkOutput("mula_clr_ignored", bus.result, 32'd41);
    tick();
    ref_acc = 32'd41;

    // Reset during MULA aborts the operation and clears the accumulator
    $display("[TB] reset mid-mula");
    applyStimulus(4'b0101, 32'd7, 32'd9, 5'd0, 1'b0);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("midreset_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("midreset_in_ready", {31'b0, bus.in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    ref_acc = 32'h0;
    tick();
    runOp("mula_after_reset", 4'b0101, 32'd2, 32'd3, 5'd0, 1'b0, 32'd6, 1'b0, 1'b0, 33, 32);
    ref_acc = 32'd6;

    // Backpressure, then a same-edge consume and accept
    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(4'b0010, 32'd100, 32'd23, 5'd0, 1'b0);
    checkOutput("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("bp_result", bus.result, 32'd123);
    repeat (3) tick();
    checkOutput("bp_hold_result", bus.result, 32'd123);
    checkOutput("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    applyStimulus(4'b0001, 32'hA0, 32'h0B, 5'd0, 1'b0);
    checkOutput("b2b_out_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("b2b_result", bus.result, 32'hAB);
    tick();
    checkOutput("b2b_consumed", {31'b0, bus.out_valid}, 32'd0);

    // Randomized operations against the reference model
    $display("[TB] random run");
    for (int i = 0; i < 40; i++) begin
      runModelOp("rand", 4'($urandom_range(0, 15)), $urandom, $urandom,
                 5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
